// File: rtl/p4_output_port_steer_pkg.sv
// Shared constants, FSM encoding and SUME dst_port decode for the output port steer.
package p4_output_steer_pkg;

  localparam int NF0 = 0;
  localparam int NF1 = 1;
  localparam int NF2 = 2;
  localparam int NF3 = 3;
  localparam int DMA = 4;
  localparam int NPORT_FIXED = 5;

  localparam int DST_PORT_LSB = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } steer_state_e;

  // Even dst_port bits select physical ports; every odd bit is a DMA queue.
  function automatic logic [NPORT_FIXED-1:0] dst_decode(input logic [7:0] dst);
    logic [NPORT_FIXED-1:0] m;
    m      = '0;
    m[NF0] = dst[0];
    m[NF1] = dst[2];
    m[NF2] = dst[4];
    m[NF3] = dst[6];
    m[DMA] = dst[1] | dst[3] | dst[5] | dst[7];
    return m;
  endfunction

endpackage

// File: rtl/p4_output_port_steer_if.sv
// AXI-Stream bundle used for the merged input and each per-port output.
interface p4_output_port_steer_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 304
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/p4_output_port_steer_sat_counter.sv
// Saturating event counter; holds at all-ones once reached.
module steer_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/p4_output_port_steer.sv
// Fans the merged stream out to nf0..nf3/dma by tuser dst_port, with multicast
// partial-acceptance tracking. Statistics counters are built when P4_OUTPUT_STEER_STATS_EN is defined.
//
// state   | meaning
// IDLE    | next beat is SOP; mask decoded live from its tuser
// FWD     | mid-packet; mask latched at SOP
// DROP    | mid-packet with no destination; beats swallowed until tlast
module p4_output_port_steer
  import p4_output_steer_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 304,
  parameter int C_S_AXIS_TUSER_WIDTH = 304,
  parameter int NUM_PORTS            = 5,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                           axis_aclk,
  input  logic                           axis_resetn,
  p4_output_port_steer_if.slave          s_axis,
  p4_output_port_steer_if.master         m_axis_0,
  p4_output_port_steer_if.master         m_axis_1,
  p4_output_port_steer_if.master         m_axis_2,
  p4_output_port_steer_if.master         m_axis_3,
  p4_output_port_steer_if.master         m_axis_4,
  output logic                           pkt_drop,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] port_pkt_cnt,
  output logic [CNT_WIDTH-1:0]           drop_pkt_cnt
);

  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_data;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_user;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    m_data;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_keep;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_user;
  logic                              s_valid, s_last, s_ready, s_xfer;

  steer_state_e         state_q, state_d;
  logic [NUM_PORTS-1:0] mask_q, mask_d;
  logic [NUM_PORTS-1:0] sent_q, sent_d;
  logic                 pkt_drop_q;

  logic [NUM_PORTS-1:0] dmask, act_mask, m_valid, m_ready, accept;
  logic                 drop_mode, beat_done, drop_last;

  assign s_data  = s_axis.tdata;
  assign s_user  = s_axis.tuser;
  assign s_valid = s_axis.tvalid;
  assign s_last  = s_axis.tlast;
  assign m_data  = s_data;
  assign m_keep  = s_axis.tkeep;
  assign m_user  = s_user;
  assign dmask   = dst_decode(s_user[DST_PORT_LSB +: 8]);

  assign m_ready = {m_axis_4.tready, m_axis_3.tready, m_axis_2.tready,
                    m_axis_1.tready, m_axis_0.tready};

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    act_mask  = '0;
    drop_mode = 1'b0;
    s_ready   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        act_mask  = dmask;
        drop_mode = (dmask == '0);
      end
      ST_FWD:  act_mask = mask_q;
      ST_DROP: drop_mode = 1'b1;
      default: ;
    endcase

    // A port that already took this beat is masked off so it never sees a duplicate.
    m_valid   = {NUM_PORTS{s_valid}} & act_mask & ~sent_q;
    accept    = m_valid & m_ready;
    beat_done = s_valid & (|act_mask) & (&(~act_mask | sent_q | accept));

    if (state_q == ST_DROP) s_ready = 1'b1;
    else if (drop_mode)     s_ready = s_valid;
    else                    s_ready = beat_done;

    s_xfer    = s_valid & s_ready;
    sent_d    = s_xfer ? '0 : (sent_q | accept);
    drop_last = s_xfer & drop_mode & s_last;

    case (state_q)
      ST_IDLE: begin
        if (s_xfer && !s_last) begin
          if (drop_mode) begin
            state_d = ST_DROP;
          end else begin
            state_d = ST_FWD;
            mask_d  = dmask;
          end
        end
      end
      ST_FWD, ST_DROP: begin
        if (s_xfer && s_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      sent_q     <= '0;
      pkt_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      sent_q     <= sent_d;
      pkt_drop_q <= drop_last;
    end
  end

  assign s_axis.tready = s_ready;
  assign pkt_drop      = pkt_drop_q;

  assign m_axis_0.tdata  = m_data;
  assign m_axis_0.tkeep  = m_keep;
  assign m_axis_0.tuser  = m_user;
  assign m_axis_0.tlast  = s_last;
  assign m_axis_0.tvalid = m_valid[NF0];

  assign m_axis_1.tdata  = m_data;
  assign m_axis_1.tkeep  = m_keep;
  assign m_axis_1.tuser  = m_user;
  assign m_axis_1.tlast  = s_last;
  assign m_axis_1.tvalid = m_valid[NF1];

  assign m_axis_2.tdata  = m_data;
  assign m_axis_2.tkeep  = m_keep;
  assign m_axis_2.tuser  = m_user;
  assign m_axis_2.tlast  = s_last;
  assign m_axis_2.tvalid = m_valid[NF2];

  assign m_axis_3.tdata  = m_data;
  assign m_axis_3.tkeep  = m_keep;
  assign m_axis_3.tuser  = m_user;
  assign m_axis_3.tlast  = s_last;
  assign m_axis_3.tvalid = m_valid[NF3];

  assign m_axis_4.tdata  = m_data;
  assign m_axis_4.tkeep  = m_keep;
  assign m_axis_4.tuser  = m_user;
  assign m_axis_4.tlast  = s_last;
  assign m_axis_4.tvalid = m_valid[DMA];

`ifdef P4_OUTPUT_STEER_STATS_EN
  logic [NUM_PORTS-1:0] port_inc;
  assign port_inc = {NUM_PORTS{s_xfer & s_last}} & act_mask;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port_cnt
    steer_sat_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk_i   (axis_aclk),
      .rst_n_i (axis_resetn),
      .inc_i   (port_inc[p]),
      .cnt_o   (port_pkt_cnt[p*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  steer_sat_counter #(.W(CNT_WIDTH)) u_drop_cnt (
    .clk_i   (axis_aclk),
    .rst_n_i (axis_resetn),
    .inc_i   (drop_last),
    .cnt_o   (drop_pkt_cnt)
  );
`else
  assign port_pkt_cnt = '0;
  assign drop_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_p4_output_port_steer.sv
// Directed bench for p4_output_port_steer: single-beat vector table plus multi-cycle sequences.
module tb_p4_output_port_steer;

  localparam int DW = 256;
  localparam int UW = 304;
  localparam int CW = 32;
  localparam int NP = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  p4_output_port_steer_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
  p4_output_port_steer_if #(.DATA_W(DW), .USER_W(UW)) m_if0 ();
  p4_output_port_steer_if #(.DATA_W(DW), .USER_W(UW)) m_if1 ();
  p4_output_port_steer_if #(.DATA_W(DW), .USER_W(UW)) m_if2 ();
  p4_output_port_steer_if #(.DATA_W(DW), .USER_W(UW)) m_if3 ();
  p4_output_port_steer_if #(.DATA_W(DW), .USER_W(UW)) m_if4 ();

  logic              pkt_drop;
  logic [NP*CW-1:0]  port_cnt;
  logic [CW-1:0]     drop_cnt;
  logic [NP-1:0]     rdy;
  logic [NP-1:0]     mv;

  assign m_if0.tready = rdy[0];
  assign m_if1.tready = rdy[1];
  assign m_if2.tready = rdy[2];
  assign m_if3.tready = rdy[3];
  assign m_if4.tready = rdy[4];
  assign mv = {m_if4.tvalid, m_if3.tvalid, m_if2.tvalid, m_if1.tvalid, m_if0.tvalid};

  p4_output_port_steer dut (
    .axis_aclk    (clk),
    .axis_resetn  (rst_n),
    .s_axis       (s_if),
    .m_axis_0     (m_if0),
    .m_axis_1     (m_if1),
    .m_axis_2     (m_if2),
    .m_axis_3     (m_if3),
    .m_axis_4     (m_if4),
    .pkt_drop     (pkt_drop),
    .port_pkt_cnt (port_cnt),
    .drop_pkt_cnt (drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_port[NP];
  int exp_drop;

  typedef struct packed {
    logic        v;
    logic [7:0]  dst;
    logic [4:0]  rdy;
    logic [4:0]  ev;
    logic        es;
    logic        ed;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] exp_cnt(input int v);
`ifdef P4_OUTPUT_STEER_STATS_EN
    return CW'(v);
`else
    return '0;
`endif
  endfunction

  task automatic check_cnts(input string tag);
    for (int p = 0; p < NP; p++)
      chk($sformatf("%s_port_cnt%0d", tag, p), 64'(port_cnt[p*CW +: CW]), 64'(exp_cnt(exp_port[p])));
    chk($sformatf("%s_drop_cnt", tag), 64'(drop_cnt), 64'(exp_cnt(exp_drop)));
  endtask

  task automatic drive(input logic v, input logic [7:0] dst, input logic last, input logic [31:0] tag);
    s_if.tvalid = v;
    s_if.tuser = '0;
    s_if.tuser[31:24] = dst;
    s_if.tuser[UW-1 -: 32] = tag;
    s_if.tdata = {8{tag}};
    s_if.tkeep = '1;
    s_if.tlast = last;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] dl[5];
    int acc0, acc4;

    for (int p = 0; p < NP; p++) exp_port[p] = 0;
    exp_drop = 0;

    //          v     dst     rdy       exp_valid  sready drop
    tbl[0]  = '{1'b1, 8'h01, 5'b11111, 5'b00001, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'h04, 5'b11111, 5'b00010, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'h10, 5'b11111, 5'b00100, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'h40, 5'b11111, 5'b01000, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 8'h08, 5'b11111, 5'b10000, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 8'h02, 5'b11111, 5'b10000, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'hA0, 5'b11111, 5'b10000, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'h55, 5'b11111, 5'b01111, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 8'hFF, 5'b11111, 5'b11111, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 8'h10, 5'b11011, 5'b00100, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h10, 5'b11111, 5'b00000, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'h00, 5'b00000, 5'b00000, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 8'h03, 5'b00000, 5'b10001, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 5'b11111, 5'b00000, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'h03, 5'b11111, 5'b10001, 1'b1, 1'b0};

    dl[0] = 8'h01; dl[1] = 8'h04; dl[2] = 8'h10; dl[3] = 8'h40; dl[4] = 8'h08;

    // reset state
    rdy = '1;
    drive(1'b0, 8'h00, 1'b0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", 64'(mv), 64'(0));
    chk("rst_sready", 64'(s_if.tready), 64'(0));
    chk("rst_pkt_drop", 64'(pkt_drop), 64'(0));
    check_cnts("rst");
    rst_n = 1'b1;
    next_cycle();

    // single-beat vector table
    for (int i = 0; i < 15; i++) begin
      rdy = tbl[i].rdy;
      drive(tbl[i].v, tbl[i].dst, 1'b1, 32'h1000 + 32'(i));
      @(negedge clk);
      chk($sformatf("tbl%0d_mvalid", i), 64'(mv), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_sready", i), 64'(s_if.tready), 64'(tbl[i].es));
      chk($sformatf("tbl%0d_pkt_drop", i), 64'(pkt_drop), 64'(tbl[i].ed));
      chk($sformatf("tbl%0d_data", i), m_if3.tdata[63:0], {2{32'h1000 + 32'(i)}});
      if (tbl[i].v && tbl[i].es) begin
        for (int p = 0; p < NP; p++) if (tbl[i].ev[p]) exp_port[p]++;
        if (tbl[i].dst == 8'h00) exp_drop++;
      end
      next_cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 32'h0);
    rdy = '1;
    @(negedge clk);
    check_cnts("tbl");
    next_cycle();

    // 3-beat packet to nf2
    for (int b = 0; b < 3; b++) begin
      drive(1'b1, 8'h10, b == 2, 32'hA000 + 32'(b));
      @(negedge clk);
      chk($sformatf("nf2_b%0d_mvalid", b), 64'(mv), 64'(5'b00100));
      chk($sformatf("nf2_b%0d_sready", b), 64'(s_if.tready), 64'(1));
      chk($sformatf("nf2_b%0d_data", b), 64'(m_if2.tdata[31:0]), 64'(32'hA000 + 32'(b)));
      chk($sformatf("nf2_b%0d_last", b), 64'(m_if2.tlast), 64'(b == 2));
      next_cycle();
    end
    exp_port[2]++;
    drive(1'b0, 8'h00, 1'b0, 32'h0);
    @(negedge clk);
    check_cnts("nf2");
    next_cycle();

    // multicast nf0+dma with dma stalled for 4 cycles
    acc0 = 0;
    acc4 = 0;
    rdy = 5'b00001;
    drive(1'b1, 8'h03, 1'b0, 32'hB000);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) rdy = 5'b11111;
      @(negedge clk);
      chk($sformatf("mc_c%0d_mvalid", c), 64'(mv), 64'(c == 0 ? 5'b10001 : 5'b10000));
      chk($sformatf("mc_c%0d_sready", c), 64'(s_if.tready), 64'(c == 4));
      if (mv[0] && rdy[0]) acc0++;
      if (mv[4] && rdy[4]) acc4++;
      next_cycle();
    end
    drive(1'b1, 8'h03, 1'b1, 32'hB001);
    @(negedge clk);
    chk("mc_b1_mvalid", 64'(mv), 64'(5'b10001));
    chk("mc_b1_sready", 64'(s_if.tready), 64'(1));
    if (mv[0] && rdy[0]) acc0++;
    if (mv[4] && rdy[4]) acc4++;
    next_cycle();
    chk("mc_nf0_beats", 64'(acc0), 64'(2));
    chk("mc_dma_beats", 64'(acc4), 64'(2));
    exp_port[0]++;
    exp_port[4]++;

    // 4-beat drop
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 8'h00, b == 3, 32'hD000 + 32'(b));
      @(negedge clk);
      chk($sformatf("drop_b%0d_mvalid", b), 64'(mv), 64'(0));
      chk($sformatf("drop_b%0d_sready", b), 64'(s_if.tready), 64'(1));
      chk($sformatf("drop_b%0d_pkt_drop", b), 64'(pkt_drop), 64'(0));
      next_cycle();
    end
    exp_drop++;
    drive(1'b0, 8'h00, 1'b0, 32'h0);
    @(negedge clk);
    chk("drop_pulse", 64'(pkt_drop), 64'(1));
    check_cnts("drop");
    next_cycle();
    @(negedge clk);
    chk("drop_pulse_end", 64'(pkt_drop), 64'(0));
    next_cycle();

    // five back-to-back single-beat packets
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, dl[i], 1'b1, 32'hE000 + 32'(i));
      @(negedge clk);
      chk($sformatf("b2b%0d_mvalid", i), 64'(mv), 64'(5'b00001 << i));
      chk($sformatf("b2b%0d_sready", i), 64'(s_if.tready), 64'(1));
      exp_port[i]++;
      next_cycle();
    end

    // tuser changes mid-packet; mask must stay on nf1
    for (int b = 0; b < 3; b++) begin
      drive(1'b1, b == 0 ? 8'h04 : 8'h10, b == 2, 32'hF000 + 32'(b));
      @(negedge clk);
      chk($sformatf("stable_b%0d_mvalid", b), 64'(mv), 64'(5'b00010));
      chk($sformatf("stable_b%0d_sready", b), 64'(s_if.tready), 64'(1));
      next_cycle();
    end
    exp_port[1]++;
    drive(1'b0, 8'h00, 1'b0, 32'h0);
    @(negedge clk);
    check_cnts("stable");
    next_cycle();

    // reset mid-packet, then next beat decoded as SOP
    for (int b = 0; b < 2; b++) begin
      drive(1'b1, 8'h40, 1'b0, 32'h5000 + 32'(b));
      @(negedge clk);
      chk($sformatf("mid_b%0d_mvalid", b), 64'(mv), 64'(5'b01000));
      next_cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 32'h0);
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) exp_port[p] = 0;
    exp_drop = 0;
    @(negedge clk);
    chk("midrst_mvalid", 64'(mv), 64'(0));
    chk("midrst_sready", 64'(s_if.tready), 64'(0));
    chk("midrst_pkt_drop", 64'(pkt_drop), 64'(0));
    check_cnts("midrst");
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    drive(1'b1, 8'h01, 1'b1, 32'h5002);
    @(negedge clk);
    chk("postrst_mvalid", 64'(mv), 64'(5'b00001));
    chk("postrst_sready", 64'(s_if.tready), 64'(1));
    exp_port[0]++;
    next_cycle();
    drive(1'b0, 8'h00, 1'b0, 32'h0);
    @(negedge clk);
    check_cnts("postrst");
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/p4_output_port_steer.md
Name: p4_output_port_steer

Overview:
- Sits directly downstream of the virtual-switch output merger and upstream of the per-port output queues.
- Consumes the single merged AXI-Stream and decodes the SUME dst_port field from tuser.
- Fans each packet out to the selected subset of 5 master streams: nf0..nf3 and dma.
- Supports multicast with per-port partial-acceptance tracking; drops packets with no destination.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master tdata width (tkeep = width/8)
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width; must equal master width
- C_M_AXIS_TUSER_WIDTH, 304, master tuser width
- C_S_AXIS_TUSER_WIDTH, 304, slave tuser width; must equal master width
- NUM_PORTS, 5, number of master ports (fixed order: nf0, nf1, nf2, nf3, dma)
- CNT_WIDTH, 32, width of statistics counters

Ports:
- axis_aclk  in  1  clock
- axis_resetn  in  1  reset
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/304/1/1  merged input stream
- s_axis_tready  out  1  input ready
- m_axis_<p>_tdata/tkeep/tuser/tlast  out  256/32/304/1  per-port copy of input, p in {0,1,2,3,4}
- m_axis_<p>_tvalid  out  1  per-port valid
- m_axis_<p>_tready  in  1  per-port ready
- pkt_drop  out  1  one-cycle pulse when a dropped packet's last beat is consumed
- port_pkt_cnt  out  NUM_PORTS*CNT_WIDTH  per-port packet counters, port p in slice p
- drop_pkt_cnt  out  CNT_WIDTH  dropped-packet counter

Interface fact: one clock; reset is asynchronous and active-low; clock port axis_aclk, reset port axis_resetn.

Behaviour:
- Reset values: state=IDLE, mask=0, sent=0, pkt_drop=0, all counters=0, all m_tvalid=0, s_axis_tready=0.
- Destination decode from tuser[31:24]:
  - nf0=bit24, nf1=bit26, nf2=bit28, nf3=bit30.
  - dma = OR of bits 25, 27, 29, 31.
  - Result is the 5-bit dmask.
- Data, keep, user and last go combinationally to all master ports. Zero-cycle latency; no data buffering.
- State machine (states IDLE, FWD, DROP):
  - IDLE: the current beat is SOP and the active mask is dmask (combinational). If dmask==0, treat as DROP immediately.
  - FWD: the active mask is the mask register latched at SOP. The mask stays stable for the whole packet even if later tuser changes.
  - DROP: s_axis_tready=1 and no master tvalid. Consume beats until tlast, then return to IDLE.
- Fan-out handshake, within IDLE/FWD:
  - m_axis_<p>_tvalid = s_axis_tvalid & mask[p] & ~sent[p]. Valid never depends on that port's own ready.
  - A port accepts when its valid & ready; its sent[p] is then set.
  - A beat is done when, for every mask bit, sent[p] is set or the port accepts this cycle.
  - s_axis_tready = beat done (only asserted when s_axis_tvalid=1 and the mask is nonzero).
  - On s_axis transfer, sent clears to 0. Ports that accepted early see no duplicate.
- Transitions:
  - IDLE --SOP transfer, !tlast, dmask!=0--> FWD, latching mask=dmask.
  - IDLE --SOP transfer with tlast--> IDLE. Single-beat packets never leave IDLE.
  - FWD --transfer with tlast--> IDLE.
  - IDLE --dmask==0 beat consumed, !tlast--> DROP.
  - DROP --tlast consumed--> IDLE.
- pkt_drop pulses in the cycle after the dropped packet's tlast beat is consumed, including single-beat drops from IDLE.
- Reset asserted mid-packet: state returns to IDLE and sent clears. The first beat seen after reset is treated as SOP.
- No packet-length limit; back-to-back packets proceed with no idle cycle.

Optional Feature:
- Macro: P4_OUTPUT_STEER_STATS_EN.
- Defined:
  - port_pkt_cnt[p] increments by 1 on each transfer of a tlast beat with mask[p]=1.
  - drop_pkt_cnt increments on each dropped packet.
  - All counters saturate at all-ones and are readable live.
- Undefined: both counter outputs are tied to 0; pkt_drop is still generated.

Decomposition:
- Package p4_output_steer_pkg holds:
  - port index constants: NF0=0, NF1=1, NF2=2, NF3=3, DMA=4;
  - DST_PORT_LSB=24;
  - the state encoding;
  - the dmask decode function.
- One natural sub-module, steer_sat_counter: a CNT_WIDTH saturating counter with inc input. It is instantiated NUM_PORTS+1 times under the macro.

Test Plan:
- 3-beat packet, tuser[31:24]=0x10, all readies high -> only m_axis_2 carries 3 beats with identical data; s_axis_tready high all 3 cycles; port_pkt_cnt[2]=1.
- 2-beat packet, dst=0x03 (nf0+dma); nf0 ready high, dma ready low for 4 cycles then high:
  - nf0 accepts beat 0 once, its tvalid drops, no duplicate;
  - s_axis_tready rises only when dma accepts;
  - both ports receive 2 beats.
- 4-beat packet with dst=0x00 -> no master tvalid; 4 beats consumed; pkt_drop=1 for exactly one cycle after tlast; drop_pkt_cnt=1.
- Five back-to-back single-beat packets, dst cycling nf0, nf1, nf2, nf3, dma(bit 27) -> one beat per cycle, each on the correct port, state stays IDLE.
- Packet to nf1 whose tuser changes to dst=0x10 on beat 2 -> all beats still go to nf1.
- Reset asserted after beat 1 of a 5-beat packet -> outputs return to reset values; the next beat is decoded as SOP from its own tuser.
